lcd_bus_responder: RTL
======================

// Module: lcd_bus_responder
// PURPOSE
//   Display-side end of the HD44780-style parallel LCD bus driven by tt_um_lcd_controller_Andres078.
//   Samples E/RS/RW/D, executes the instruction subset, holds DDRAM, answers busy-flag/AC and data reads.
//   Synthesizable responder for loopback self-test in the tile and for cocotb checking of controller timing.
// PARAMETERS
//   DDRAM_DEPTH       80    DDRAM bytes; AC wraps modulo this value (<=128)
//   BUSY_CYCLES       40    clk cycles busy after any write except clear/home
//   LONG_BUSY_CYCLES  1600  clk cycles busy after clear (0x01) / home (0x02)
//   SYNC_STAGES       2     flops in E/RS/RW/D input synchronizer
// PORTS
//   clk             in   1  clock (sole clock domain)
//   rst_n           in   1  synchronous, active-low reset
//   lcd_e           in   1  enable strobe from controller (async to clk)
//   lcd_rs          in   1  0=instruction, 1=data
//   lcd_rw          in   1  0=write, 1=read
//   lcd_d_in        in   8  bus data from controller
//   lcd_d_out       out  8  read data to controller
//   lcd_d_oe        out  1  1 = responder drives bus
//   busy_o          out  1  busy flag (BF)
//   ac_o            out  7  address counter
//   disp_on/cur_on/blink_on  out  1 each  display-control bits D/C/B
//   dbg_addr        in   7  DDRAM debug read address
//   dbg_data        out  8  DDRAM[dbg_addr], registered, 1-cycle latency
//   busy_violation  out  1  1-cycle pulse: write strobe arrived while busy
// BEHAVIOUR
//   Reset: ac=0, I/D=1, shift=0, D/C/B=0, busy=0, state IDLE, lcd_d_oe=0, lcd_d_out=0,
//     busy_violation=0, nibble phase=high. DDRAM not reset.
//   Strobe: E, RS, RW, D synchronized; E falling edge (sync'd) = 1-cycle "strobe".
//   Write (RW=0) on strobe:
//     busy=1 -> dropped, busy_violation pulses; strobe and busy expiry in same cycle count as busy.
//     RS=1 -> DDRAM[ac]=D; ac += I/D ? +1 : -1, wrapping 0 <-> DDRAM_DEPTH-1; BUSY_CYCLES.
//     RS=0 decode by highest set bit: 0x80 ac=D[6:0] mod DEPTH; 0x40 CGRAM addr, accepted, no effect;
//       0x20 function set (DL); 0x10 shift, S/C=0 moves ac by R/L, S/C=1 no-op; 0x08 D/C/B;
//       0x04 I/D, S; 0x02 home, ac=0; 0x01 clear; 0x00 no-op, not busy.
//   States: IDLE -> EXEC (count BUSY or LONG_BUSY down to 0 -> IDLE); clear: IDLE -> CLEAR
//     (write 0x20 to DDRAM[0..DEPTH-1], one addr/cycle) -> EXEC for the remaining LONG_BUSY
//     cycles, total busy = LONG_BUSY_CYCLES (LONG_BUSY_CYCLES >= DEPTH). Clear sets ac=0, I/D=1.
//   busy_o=1 in EXEC and CLEAR, asserted the cycle after the accepted strobe.
//   Read (RW=1): lcd_d_oe=1 while sync'd E high and RW=1. RS=0 -> {busy, ac}; RS=1 -> DDRAM[ac],
//     ac advances per I/D on strobe (not during busy). Output valid 1 cycle after sync'd E rise.
//   Reset mid-CLEAR/EXEC aborts immediately; DDRAM partially cleared.
// CONFIGURATION
//   LCD_NIBBLE_MODE_EN defined: function set with DL=0 selects 4-bit mode. Data on D[7:4],
//     high nibble then low; byte acts on 2nd strobe. Reads return high then low nibble on
//     D[7:4], D[3:0]=0. Busy on 1st nibble still completes the pair; violation on 2nd.
//     Instruction 0x30 (DL=1) restores 8-bit; nibble phase resets to high.
//   Undefined: DL ignored, 8-bit only, no nibble-phase logic.
// STRUCTURE
//   Package lcd_hd44780_pkg: opcode bit-position constants, state enum {IDLE,EXEC,CLEAR},
//     CLEAR_CHAR=8'h20, busy-counter width function.
//   Sub-module lcd_bus_sync: SYNC_STAGES synchronizer plus E rise/fall detect; top keeps
//     decode, FSM, busy counter, DDRAM array.
// TESTING
//   Reset, write 0x41 RS=1 -> dbg_data[0]=0x41, ac_o=1, busy_o high 40 cycles.
//   Write 0x80|0x4F, data 0x5A -> DDRAM[79]=0x5A, ac wraps to 0; I/D=0 at ac=0 -> ac=79.
//   Write 0x01 -> all 80 DDRAM bytes 0x20, ac=0, busy exactly 1600 cycles.
//   Data write during busy -> busy_violation 1 pulse, DDRAM and ac unchanged.
//   RS=0 read while busy -> lcd_d_out=0x80|ac, lcd_d_oe only while E high; RS=1 read -> DDRAM[ac], ac+1.
//   NIBBLE_EN: 0x20 then nibbles 4,1 with RS=1 -> DDRAM[0]=0x41; undefined -> 0x20 stored as data? no, treated as function set, 8-bit kept.

Source files
------------

// File: rtl/lcd_hd44780_pkg.sv
// Shared types and constants for the HD44780-style bus responder.
package lcd_hd44780_pkg;

  // Instruction class is selected by the highest set bit of the byte
  localparam int OP_DDRAM = 7;
  localparam int OP_CGRAM = 6;
  localparam int OP_FUNC  = 5;
  localparam int OP_SHIFT = 4;
  localparam int OP_DISP  = 3;
  localparam int OP_ENTRY = 2;
  localparam int OP_HOME  = 1;
  localparam int OP_CLEAR = 0;

  localparam logic [7:0] CLEAR_CHAR = 8'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} lcd_state_e;

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] d;
  } lcd_bus_t;

  // Counter loads max_cycles-1, so $clog2(max_cycles) bits are enough.
  function automatic int busy_cnt_w(int max_cycles);
    return (max_cycles < 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous LCD bus into clk and detects E edges.
module lcd_bus_sync
  import lcd_hd44780_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  lcd_bus_t bus_raw,
  output lcd_bus_t bus,
  output logic     e_rise,
  output logic     e_fall
);
  lcd_bus_t [SYNC_STAGES-1:0] sync_q;
  logic                       e_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      e_prev <= 1'b0;
    end else begin
      sync_q[0] <= bus_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_prev <= sync_q[SYNC_STAGES-1].e;
    end
  end

  assign bus    = sync_q[SYNC_STAGES-1];
  assign e_rise = bus.e & ~e_prev;
  assign e_fall = e_prev & ~bus.e;

endmodule

// File: rtl/lcd_bus_responder.sv
// Display-side HD44780-style bus responder: decode, busy FSM, DDRAM, BF/AC and data reads.
// Optional 4-bit interface enabled by defining LCD_NIBBLE_MODE_EN.
module lcd_bus_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int DDRAM_DEPTH      = 80,
  parameter int BUSY_CYCLES      = 40,
  parameter int LONG_BUSY_CYCLES = 1600,
  parameter int SYNC_STAGES      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_d_in,
  output logic [7:0] lcd_d_out,
  output logic       lcd_d_oe,
  output logic       busy_o,
  output logic [6:0] ac_o,
  output logic       disp_on,
  output logic       cur_on,
  output logic       blink_on,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy_violation
);
  localparam int CW = busy_cnt_w((LONG_BUSY_CYCLES > BUSY_CYCLES) ? LONG_BUSY_CYCLES : BUSY_CYCLES);
  localparam logic [CW-1:0] SHORT_LD = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_BUSY_CYCLES - 1);
  localparam logic [6:0]    LAST     = 7'(DDRAM_DEPTH - 1);

  lcd_bus_t      bus_raw, bus;
  logic          e_rise, e_fall;
  lcd_state_e    state;
  logic [CW-1:0] cnt;
  logic [6:0]    ac, clr_addr;
  logic          inc;
  logic [7:0]    ddram [DDRAM_DEPTH];
  logic [7:0]    wr_byte, rd_raw, rd_fmt;
  logic          wr_fire, rd_fire, idle, data_wr;

  function automatic logic [6:0] ac_step(logic [6:0] a, logic up);
    if (up) return (a == LAST) ? 7'd0 : a + 7'd1;
    return (a == 7'd0) ? LAST : a - 7'd1;
  endfunction

  assign bus_raw = '{e: lcd_e, rs: lcd_rs, rw: lcd_rw, d: lcd_d_in};

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_raw(bus_raw),
    .bus    (bus),
    .e_rise (e_rise),
    .e_fall (e_fall)
  );

  assign idle    = (state == ST_IDLE);
  assign rd_raw  = bus.rs ? ddram[ac] : {busy_o, ac};
  assign data_wr = rst_n & wr_fire & idle & bus.rs;
  assign ac_o    = ac;

`ifdef LCD_NIBBLE_MODE_EN
  logic       nib_mode, nib_hi;
  logic [3:0] nib_hold;

  // In 4-bit mode only the low-nibble strobe completes a transfer
  always_comb begin
    wr_byte = bus.d;
    wr_fire = e_fall & ~bus.rw;
    rd_fire = e_fall & bus.rw;
    rd_fmt  = rd_raw;
    if (nib_mode) begin
      wr_byte = {nib_hold, bus.d[7:4]};
      wr_fire = e_fall & ~bus.rw & ~nib_hi;
      rd_fire = e_fall & bus.rw & ~nib_hi;
      rd_fmt  = nib_hi ? {rd_raw[7:4], 4'h0} : {rd_raw[3:0], 4'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nib_mode <= 1'b0;
      nib_hi   <= 1'b1;
      nib_hold <= 4'h0;
    end else begin
      if (nib_mode && e_fall) begin
        nib_hi <= ~nib_hi;
        if (nib_hi) nib_hold <= bus.d[7:4];
      end
      if (wr_fire && idle && !bus.rs && wr_byte[7:5] == 3'b001) begin
        nib_mode <= ~wr_byte[4];
        nib_hi   <= 1'b1;
      end
    end
  end
`else
  assign wr_byte = bus.d;
  assign wr_fire = e_fall & ~bus.rw;
  assign rd_fire = e_fall & bus.rw;
  assign rd_fmt  = rd_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      clr_addr       <= '0;
      ac             <= '0;
      inc            <= 1'b1;
      disp_on        <= 1'b0;
      cur_on         <= 1'b0;
      blink_on       <= 1'b0;
      busy_o         <= 1'b0;
      busy_violation <= 1'b0;
      lcd_d_oe       <= 1'b0;
      lcd_d_out      <= '0;
    end else begin
      busy_violation <= 1'b0;
      lcd_d_oe       <= bus.e & bus.rw;
      if (e_rise && bus.rw) lcd_d_out <= rd_fmt;

      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 7'd1;
          if (clr_addr == LAST && cnt == '0) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            if (clr_addr == LAST) state <= ST_EXEC;
            cnt <= cnt - 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase

      // Expiry and a new strobe in the same cycle still counts as busy
      if (wr_fire) begin
        if (!idle) begin
          busy_violation <= 1'b1;
        end else if (bus.rs) begin
          ac     <= ac_step(ac, inc);
          state  <= ST_EXEC;
          cnt    <= SHORT_LD;
          busy_o <= 1'b1;
        end else begin
          if (wr_byte[OP_DDRAM])      ac <= 7'(int'(wr_byte[6:0]) % DDRAM_DEPTH);
          else if (wr_byte[OP_CGRAM] || wr_byte[OP_FUNC]) begin end
          else if (wr_byte[OP_SHIFT]) begin
            if (!wr_byte[3]) ac <= ac_step(ac, wr_byte[2]);
          end
          else if (wr_byte[OP_DISP])  {disp_on, cur_on, blink_on} <= wr_byte[2:0];
          else if (wr_byte[OP_ENTRY]) inc <= wr_byte[1];
          else if (wr_byte[OP_HOME])  ac <= '0;
          else if (wr_byte[OP_CLEAR]) begin
            ac  <= '0;
            inc <= 1'b1;
          end

          if (wr_byte == 8'h01) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            cnt      <= LONG_LD;
            busy_o   <= 1'b1;
          end else if (wr_byte[7:1] == 7'h01) begin
            state  <= ST_EXEC;
            cnt    <= LONG_LD;
            busy_o <= 1'b1;
          end else if (wr_byte != 8'h00) begin
            state  <= ST_EXEC;
            cnt    <= SHORT_LD;
            busy_o <= 1'b1;
          end
        end
      end

      if (rd_fire && bus.rs && idle) ac <= ac_step(ac, inc);
    end
  end

  // DDRAM is intentionally not reset; a reset mid-clear leaves it partially cleared
  always_ff @(posedge clk) begin
    if (rst_n && state == ST_CLEAR) ddram[clr_addr] <= CLEAR_CHAR;
    else if (data_wr)               ddram[ac]       <= wr_byte;
    dbg_data <= (int'(dbg_addr) < DDRAM_DEPTH) ? ddram[dbg_addr] : 8'h00;
  end

endmodule
